// File: rtl/makeup_limiter.sv
// makeup_limiter: makeup gain with saturation, then a peak limiter whose gain is found by serial division
module makeup_limiter #(
  parameter int          W_TOTAL      = 16,
  parameter int          W_FRAC       = 15,
  parameter logic [15:0] MAKEUP_GAIN  = 16'h6000,
  parameter logic [15:0] CEIL_LIN     = 16'h7000,
  parameter int          HOLD_SAMPLES = 64,
  parameter logic [15:0] RELEASE_STEP = 16'h0010
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_ce,
  input  logic [W_TOTAL-1:0] i_data,
  output logic [W_TOTAL-1:0] o_data,
  output logic               o_ce,
  output logic               o_busy,
  output logic               o_overrun,
  output logic [15:0]        o_clip_cnt
);
  localparam int W = W_TOTAL;
  localparam logic [1:0] IDLE = 2'd0, DIV = 2'd1, APPLY = 2'd2, OUT = 2'd3;
  localparam logic signed [2*W-1:0] PMAX = (2*W)'((2**(W-1)) - 1);
  localparam logic signed [2*W-1:0] PMIN = -PMAX;
  logic [1:0] state;
  logic signed [W-1:0] x_sat, x_sat_n, y;
  logic [W-2:0] mag, mag_n, rem, tsub;
  logic [W-1:0] num, target, tdiv;
  logic [15:0] gain_r, hold_cnt;
  logic [16:0] gsum;
  logic [$clog2(W)-1:0] dcnt;
  logic signed [2*W-1:0] p, ps;
  logic signed [2*W:0] po;
  logic clip, ge;
  assign o_busy = state != IDLE;
  always_comb begin
    p = (2*W)'($signed(i_data)) * (2*W)'({1'b0, MAKEUP_GAIN});
    ps = p >>> (W_FRAC - 1);
    clip = (ps > PMAX) || (ps < PMIN);
    x_sat_n = ps > PMAX ? PMAX[W-1:0] : ps < PMIN ? PMIN[W-1:0] : ps[W-1:0];
    mag_n = x_sat_n[W-1] ? (W-1)'(-x_sat_n) : x_sat_n[W-2:0];
    tdiv = {rem, num[W-1]};
    ge = tdiv >= {1'b0, mag};
    tsub = ge ? (W-1)'(tdiv - {1'b0, mag}) : tdiv[W-2:0];
    gsum = {1'b0, gain_r} + {1'b0, RELEASE_STEP};
    po = x_sat * $signed({1'b0, gain_r});
    y = W'(po >>> W_FRAC);
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      o_data     <= '0;
      o_ce       <= 1'b0;
      o_overrun  <= 1'b0;
      o_clip_cnt <= '0;
      gain_r     <= 16'h8000;
      hold_cnt   <= '0;
      x_sat      <= '0;
      mag        <= '0;
      target     <= '0;
      rem        <= '0;
      num        <= '0;
      dcnt       <= '0;
    end else begin
      o_ce <= 1'b0;
      if (i_ce && state != IDLE) o_overrun <= 1'b1;
      case (state)
        IDLE: if (i_ce) begin
          x_sat <= x_sat_n;
          mag   <= mag_n;
          if (clip && o_clip_cnt != 16'hFFFF) o_clip_cnt <= o_clip_cnt + 16'd1;
          // dividend CEIL_LIN<<15: top bits preload the remainder, the rest shifts in
          rem    <= CEIL_LIN[W-1:1];
          num    <= {CEIL_LIN[0], {(W-1){1'b0}}};
          dcnt   <= '0;
          target <= {1'b1, {(W-1){1'b0}}};
          state  <= {1'b0, mag_n} > CEIL_LIN ? DIV : APPLY;
        end
        DIV: begin
          rem    <= tsub;
          num    <= num << 1;
          target <= {target[W-2:0], ge};
          dcnt   <= dcnt + 1'b1;
          if (dcnt == ($clog2(W))'(W - 1)) state <= APPLY;
        end
        APPLY: begin
          if (target < gain_r) begin
            gain_r   <= target;
            hold_cnt <= 16'(HOLD_SAMPLES);
          end else if (hold_cnt != 0) begin
            hold_cnt <= hold_cnt - 16'd1;
          end else begin
            gain_r <= gsum > {1'b0, target} ? target : gsum[15:0];
          end
          state <= OUT;
        end
        default: begin
          o_data <= y;
          o_ce   <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_makeup_limiter.sv
// tb_makeup_limiter: scoreboard bench comparing the limiter against an integer reference model
module tb_makeup_limiter;
  logic i_clk = 1'b0, i_reset_n = 1'b0, i_ce = 1'b0;
  logic [15:0] i_data = '0;
  logic [15:0] o_data, o_clip_cnt;
  logic o_ce, o_busy, o_overrun;
  typedef struct {logic [15:0] d; int due;} exp_t;
  exp_t sbq[$];
  exp_t e;
  int cyc = 0;
  int n_vec = 0, n_err = 0;
  longint g = 32768;
  int hold = 0, exp_clip = 0;
  makeup_limiter dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_data(i_data),
    .o_data(o_data), .o_ce(o_ce), .o_busy(o_busy), .o_overrun(o_overrun),
    .o_clip_cnt(o_clip_cnt)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [15:0] d, output logic [15:0] y, output int lat);
    longint x, m, t;
    bit clipped;
    x = (longint'($signed(d)) * 24576) >>> 14;
    clipped = x > 32767 || x < -32767;
    x = x > 32767 ? 32767 : x < -32767 ? -32767 : x;
    m = x < 0 ? -x : x;
    if (m > 28672) begin
      t = (longint'(28672) * 32768) / m;
      lat = 19;
    end else begin
      t = 32768;
      lat = 3;
    end
    if (t < g) begin
      g = t;
      hold = 64;
    end else if (hold != 0) hold--;
    else g = (g + 16 > t) ? t : g + 16;
    y = 16'((x * g) >>> 15);
    if (clipped && exp_clip < 65535) exp_clip++;
  endtask
  task automatic model_reset();
    g = 32768;
    hold = 0;
    exp_clip = 0;
  endtask
  task automatic do_reset();
    i_reset_n = 1'b0;
    i_ce = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    model_reset();
  endtask
  task automatic send(input logic [15:0] d);
    logic [15:0] y;
    int lat;
    model(d, y, lat);
    sbq.push_back('{y, cyc + lat});
    i_ce = 1'b1;
    i_data = d;
    @(posedge i_clk);
    #1 i_ce = 1'b0;
    repeat (lat - 1) @(posedge i_clk);
    #1;
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask
  always @(negedge i_clk)
    if (o_ce) begin
      if (sbq.size() == 0) check("spurious_oce", 1, 0);
      else begin
        e = sbq.pop_front();
        check("o_data", o_data, e.d);
        check("latency", cyc, e.due);
      end
    end
  initial begin
    logic [15:0] y;
    int lat;
    do_reset();
    check("rst_o_data", o_data, 0);
    check("rst_o_ce", o_ce, 0);
    check("rst_o_busy", o_busy, 0);
    check("rst_overrun", o_overrun, 0);
    check("rst_clip", o_clip_cnt, 0);
    send(16'h2000);
    check("bypass_clip", o_clip_cnt, exp_clip);
    send(16'h6000);
    check("limit_clip", o_clip_cnt, exp_clip);
    for (int i = 0; i < 330; i++) send(16'h1000);
    check("release_final", o_data, 16'h1800);
    send(16'h8000);
    check("negfs_clip", o_clip_cnt, exp_clip);
    // drop on the OUT cycle of a bypass sample
    model(16'h2000, y, lat);
    sbq.push_back('{y, cyc + lat});
    i_ce = 1'b1;
    i_data = 16'h2000;
    tick(1);
    i_ce = 1'b0;
    tick(1);
    i_ce = 1'b1;
    i_data = 16'h4000;
    tick(1);
    i_ce = 1'b0;
    check("out_drop_overrun", o_overrun, 1);
    tick(5);
    do_reset();
    check("rst2_overrun", o_overrun, 0);
    check("rst2_clip", o_clip_cnt, 0);
    // drop on the 5th DIV cycle
    model(16'h6000, y, lat);
    sbq.push_back('{y, cyc + lat});
    i_ce = 1'b1;
    i_data = 16'h6000;
    tick(1);
    i_ce = 1'b0;
    tick(4);
    i_ce = 1'b1;
    i_data = 16'h1234;
    tick(1);
    i_ce = 1'b0;
    tick(13);
    check("div_drop_overrun", o_overrun, 1);
    tick(3);
    // reset on the 10th DIV cycle aborts the sample
    i_ce = 1'b1;
    i_data = 16'h6000;
    tick(1);
    i_ce = 1'b0;
    tick(9);
    i_reset_n = 1'b0;
    tick(1);
    i_reset_n = 1'b1;
    model_reset();
    check("abort_busy", o_busy, 0);
    check("abort_overrun", o_overrun, 0);
    check("abort_clip", o_clip_cnt, 0);
    tick(25);
    send(16'h2000);
    for (int i = 0; i < 24; i++) send(16'($urandom_range(0, 65535)));
    tick(30);
    check("drain", sbq.size(), 0);
    check("final_clip", o_clip_cnt, exp_clip);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
